alu: RTL and testbench



---
 rtl/alu.sv | 74 +++++++
 tb/tb_alu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: RV32I integer ALU with a combinational result and a registered copy.
// Revision: 1.0
`default_nettype none

module alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      ctrl,
  output logic [XLEN-1:0] res,
  output logic            zero,
  output logic [XLEN-1:0] res_q,
  output logic            zero_q
);

  localparam int SHW = $clog2(XLEN);

  // Operation codes are {funct7[5], funct3}.
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  logic [SHW-1:0]  shamt;
  logic            lt_signed;
  logic            lt_unsigned;
  logic [XLEN-1:0] sra_val;

  assign shamt       = B[SHW-1:0];
  assign lt_signed   = $signed(A) < $signed(B);
  assign lt_unsigned = A < B;
  assign sra_val     = $unsigned($signed(A) >>> shamt);

  always_comb begin
    res = '0;
    case (ctrl)
      OP_ADD:  res = A + B;
      OP_SUB:  res = A - B;
      OP_SLL:  res = A << shamt;
      OP_SLT:  res = {{(XLEN-1){1'b0}}, lt_signed};
      OP_SLTU: res = {{(XLEN-1){1'b0}}, lt_unsigned};
      OP_XOR:  res = A ^ B;
      OP_SRL:  res = A >> shamt;
      OP_SRA:  res = sra_val;
      OP_OR:   res = A | B;
      OP_AND:  res = A & B;
      default: res = '0;
    endcase
  end

  assign zero = (res == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      res_q  <= res;
      zero_q <= zero;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for the alu combinational and registered paths.
// Revision: 1.0
`default_nettype none

module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ctrl;
  logic [31:0] res;
  logic        zero;
  logic [31:0] res_q;
  logic        zero_q;

  int tests;
  int failed;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] exp;
    string       name;
  } vec_t;

  alu #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .ctrl   (ctrl),
    .res    (res),
    .zero   (zero),
    .res_q  (res_q),
    .zero_q (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    A    = a;
    B    = b;
    ctrl = op;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'd31, 32'd32, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (res_q !== 32'd0 || zero_q !== 1'b0) begin
      $display("FAIL reset_hold: res_q=%h zero_q=%b, required res_q=00000000 zero_q=0", res_q, zero_q);
      failed++;
    end
    tests++;
    if (res !== 32'd63) begin
      $display("FAIL reset_comb: res=%h, required 0000003f", res);
      failed++;
    end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    vec_t v [6];
    v = '{
      '{32'd31,       32'd32,        4'b0000, 32'd63,        "add_31_32"},
      '{32'd5,        32'hFFFFFFFE,  4'b0000, 32'd3,         "add_5_m2"},
      '{32'd4,        32'd2,         4'b1000, 32'd2,         "sub_4_2"},
      '{32'd4,        32'hFFFFFFFE,  4'b1000, 32'd6,         "sub_4_m2"},
      '{32'h7FFFFFFF, 32'd1,         4'b0000, 32'h80000000,  "add_overflow"},
      '{32'd5,        32'd5,         4'b1000, 32'd0,         "sub_equal"}
    };
    for (int i = 0; i < 6; i++) begin
      drive(v[i].a, v[i].b, v[i].op);
      tests++;
      if (res !== v[i].exp || zero !== (v[i].exp == 32'd0)) begin
        $display("FAIL %s: res=%h zero=%b, required res=%h zero=%b",
                 v[i].name, res, zero, v[i].exp, (v[i].exp == 32'd0));
        failed++;
      end
    end
  endtask

  task automatic test_compare();
    vec_t v [9];
    v = '{
      '{32'd3,        32'd1,         4'b0010, 32'd0, "slt_3_1"},
      '{32'd1,        32'd3,         4'b0010, 32'd1, "slt_1_3"},
      '{32'd1,        32'hFFFFFFFD,  4'b0010, 32'd0, "slt_1_m3"},
      '{32'hFFFFFFFD, 32'hFFFFFFFB,  4'b0010, 32'd0, "slt_m3_m5"},
      '{32'hFFFFFFFB, 32'hFFFFFFFD,  4'b0010, 32'd1, "slt_m5_m3"},
      '{32'd7,        32'd7,         4'b0010, 32'd0, "slt_equal"},
      '{32'hC0000000, 32'd0,         4'b0011, 32'd0, "sltu_big_0"},
      '{32'd0,        32'hC0000000,  4'b0011, 32'd1, "sltu_0_big"},
      '{32'd1,        32'hFFFFFFFF,  4'b0011, 32'd1, "sltu_1_m1"}
    };
    for (int i = 0; i < 9; i++) begin
      drive(v[i].a, v[i].b, v[i].op);
      tests++;
      if (res !== v[i].exp || zero !== (v[i].exp == 32'd0)) begin
        $display("FAIL %s: res=%h zero=%b, required res=%h zero=%b",
                 v[i].name, res, zero, v[i].exp, (v[i].exp == 32'd0));
        failed++;
      end
    end
  endtask

  task automatic test_shift();
    vec_t v [11];
    v = '{
      '{32'h80000001, 32'd4,        4'b0001, 32'h00000010, "sll_4"},
      '{32'h80000001, 32'd4,        4'b0101, 32'h08000000, "srl_4"},
      '{32'h80000001, 32'd4,        4'b1101, 32'hF8000000, "sra_4"},
      '{32'h80000001, 32'h24,       4'b0001, 32'h00000010, "sll_0x24"},
      '{32'h80000001, 32'h24,       4'b0101, 32'h08000000, "srl_0x24"},
      '{32'h80000001, 32'h24,       4'b1101, 32'hF8000000, "sra_0x24"},
      '{32'h80000001, 32'd0,        4'b0001, 32'h80000001, "sll_0"},
      '{32'h80000001, 32'd0,        4'b0101, 32'h80000001, "srl_0"},
      '{32'h80000001, 32'd0,        4'b1101, 32'h80000001, "sra_0"},
      '{32'h80000001, 32'd32,       4'b0101, 32'h80000001, "srl_32"},
      '{32'h40000000, 32'd31,       4'b1101, 32'h00000000, "sra_pos_31"}
    };
    for (int i = 0; i < 11; i++) begin
      drive(v[i].a, v[i].b, v[i].op);
      tests++;
      if (res !== v[i].exp || zero !== (v[i].exp == 32'd0)) begin
        $display("FAIL %s: res=%h zero=%b, required res=%h zero=%b",
                 v[i].name, res, zero, v[i].exp, (v[i].exp == 32'd0));
        failed++;
      end
    end
  endtask

  task automatic test_logic();
    vec_t v [9];
    v = '{
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100, 32'hFF00FF00, "xor"},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b0110, 32'hFFF0FFF0, "or"},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b0111, 32'h00F000F0, "and"},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b1111, 32'h00000000, "illegal_1111"},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b1001, 32'h00000000, "illegal_1001"},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b1010, 32'h00000000, "illegal_1010"},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b1011, 32'h00000000, "illegal_1011"},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b1100, 32'h00000000, "illegal_1100"},
      '{32'hF0F0F0F0, 32'h0FF00FF0, 4'b1110, 32'h00000000, "illegal_1110"}
    };
    for (int i = 0; i < 9; i++) begin
      drive(v[i].a, v[i].b, v[i].op);
      tests++;
      if (res !== v[i].exp || zero !== (v[i].exp == 32'd0)) begin
        $display("FAIL %s: res=%h zero=%b, required res=%h zero=%b",
                 v[i].name, res, zero, v[i].exp, (v[i].exp == 32'd0));
        failed++;
      end
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst = 1'b0;
    drive(32'd31, 32'd32, 4'b0000);
    @(posedge clk);
    #1;
    tests++;
    if (res_q !== 32'd63 || zero_q !== 1'b0) begin
      $display("FAIL reg_add: res_q=%h zero_q=%b, required res_q=0000003f zero_q=0", res_q, zero_q);
      failed++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (res_q !== 32'd0 || zero_q !== 1'b0 || res !== 32'd63 || zero !== 1'b0) begin
      $display("FAIL reg_midreset: res_q=%h zero_q=%b res=%h zero=%b, required 00000000 0 0000003f 0",
               res_q, zero_q, res, zero);
      failed++;
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (res_q !== 32'd63) begin
      $display("FAIL reg_recover: res_q=%h, required 0000003f", res_q);
      failed++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(32'd5, 32'd5, 4'b1000);
    @(posedge clk);
    #1;
    tests++;
    if (res_q !== 32'd0 || zero_q !== 1'b1) begin
      $display("FAIL b2b_sub_zero: res_q=%h zero_q=%b, required res_q=00000000 zero_q=1", res_q, zero_q);
      failed++;
    end
    @(negedge clk);
    drive(32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100);
    @(posedge clk);
    #1;
    tests++;
    if (res_q !== 32'hFF00FF00 || zero_q !== 1'b0) begin
      $display("FAIL b2b_xor: res_q=%h zero_q=%b, required res_q=ff00ff00 zero_q=0", res_q, zero_q);
      failed++;
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    A      = '0;
    B      = '0;
    ctrl   = '0;
    test_reset();
    test_arith();
    test_compare();
    test_shift();
    test_logic();
    test_registered();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
